uart_rx_deframer: RTL and testbench

- UART receive path: the far end of our TX frame (start 0, LSB-first data, optional parity, stop 1).
- Oversamples RX_IN at PRESCALE clocks per bit and takes a 3-sample majority vote at mid-bit.
- Checks start glitch, parity and stop bit; presents the parallel byte with a one-cycle valid pulse.
- Sits between the RX pad synchroniser and the system register/FIFO interface.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_rx_deframer.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, legal prescale ratios, parity
// type codes and the parity function used by both the RX and TX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Callers zero-extend narrower words; the padding does not change the XOR.
    localparam int MAX_DATA_WIDTH = 32;

    // Expected parity bit for a data word under the given parity type.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic par_typ);
        return (^data) ^ (par_typ == ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing engine: per-bit edge counter plus a 3-sample mid-bit majority vote.
// sampled_bit is valid from sample_done until bit_done; no backpressure.
module uart_rx_sampler #(
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   rx_in,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   sampled_bit,
    output logic                   sample_done,
    output logic                   bit_done
);

    localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);
    localparam logic [PRESC_WIDTH-1:0] TWO = PRESC_WIDTH'(2);

    logic [PRESC_WIDTH-1:0] edge_cnt;
    logic [PRESC_WIDTH-1:0] half;
    logic [2:0]             smp;

    assign half        = prescale >> 1;
    assign bit_done    = en && (edge_cnt == prescale - ONE);
    assign sample_done = en && (edge_cnt == half + ONE);
    assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (!en || bit_done) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    // Three consecutive samples straddling the bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp <= '0;
        end else if (en) begin
            if (edge_cnt == half - TWO) begin
                smp[0] <= rx_in;
            end else if (edge_cnt == half - ONE) begin
                smp[1] <= rx_in;
            end else if (edge_cnt == half) begin
                smp[2] <= rx_in;
            end
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/data/parity/stop FSM over the oversampling sampler.
// DATA_VALID pulses one cycle after the stop bit ends; no backpressure, byte is dropped on error.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   RX_IN,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_WIDTH-1:0]  P_DATA,
    output logic                   DATA_VALID,
    output logic                   PAR_ERR,
    output logic                   STP_ERR
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_t state, state_nxt;

    logic [PRESC_WIDTH-1:0] presc_q;
    logic [PRESC_WIDTH-1:0] presc_norm;
    logic                   par_en_q;
    logic                   par_typ_q;
    logic [BCW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   par_fail;

    logic sampled_bit;
    logic sample_done;
    logic bit_done;
    logic load_cfg;
    logic complete;
    logic last_bit;
    logic par_mismatch;

    uart_rx_sampler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .en          (state != IDLE),
        .rx_in       (RX_IN),
        .prescale    (presc_q),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_done    (bit_done)
    );

    // Anything other than 16 or 32 runs at 8x.
    always_comb begin
        presc_norm = PRESC_WIDTH'(PRESC_8);
        if (PRESCALE == PRESC_WIDTH'(PRESC_16) || PRESCALE == PRESC_WIDTH'(PRESC_32)) begin
            presc_norm = PRESCALE;
        end
    end

    assign last_bit     = (bit_cnt == LAST_BIT);
    assign par_mismatch = sampled_bit != calc_parity(MAX_DATA_WIDTH'(shift_q), par_typ_q);

    always_comb begin
        state_nxt = state;
        load_cfg  = 1'b0;
        complete  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt = START;
                    load_cfg  = 1'b1;
                end
            end
            START: begin
                if (sample_done && sampled_bit) begin
                    state_nxt = IDLE;
                end else if (bit_done) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_done && last_bit) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_nxt = IDLE;
                    complete  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame configuration is frozen at the start edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q   <= PRESC_WIDTH'(PRESC_8);
            par_en_q  <= 1'b0;
            par_typ_q <= EVEN;
        end else if (load_cfg) begin
            presc_q   <= presc_norm;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_fail <= 1'b0;
        end else if (load_cfg) begin
            bit_cnt  <= '0;
            par_fail <= 1'b0;
        end else if (bit_done) begin
            if (state == DATA) begin
                shift_q[bit_cnt] <= sampled_bit;
                bit_cnt          <= last_bit ? '0 : bit_cnt + BCW'(1);
            end
            if (state == PARITY) begin
                par_fail <= par_mismatch;
            end
        end
    end

    // Flags track every completed frame; the byte only moves on a clean one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (complete) begin
                PAR_ERR <= par_fail;
                STP_ERR <= !sampled_bit;
                if (!par_fail && sampled_bit) begin
                    P_DATA     <= shift_q;
                    DATA_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomised scoreboard bench for uart_rx_deframer: a line driver builds whole
// frames, a monitor checks every DATA_VALID pulse against queued expected bytes.
module tb_uart_rx_deframer;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] PRESCALE;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;

    uart_rx_deframer #(
        .DATA_WIDTH  (DW),
        .PRESC_WIDTH (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int exp_pulses  = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_data = '0;
    logic          m_par  = 1'b0;
    logic          m_stp  = 1'b0;
    logic          prev_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding clean frame.
    always @(negedge CLK) begin
        if (RST === 1'b0 && DATA_VALID === 1'b1) begin
            pulses++;
            check("valid_one_cycle", 32'(prev_vld), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid: got P_DATA %0h with no frame outstanding", P_DATA);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("pulse_data", 32'(P_DATA), 32'(e));
                check("pulse_par_err", 32'(PAR_ERR), 32'd0);
                check("pulse_stp_err", 32'(STP_ERR), 32'd0);
            end
        end
        prev_vld <= (RST === 1'b0) && (DATA_VALID === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic int eff_presc(input logic [PW-1:0] p);
        return (p == 16 || p == 32) ? int'(p) : 8;
    endfunction

    // One bit period; optionally flips the line for the single centre cycle.
    task automatic send_bit(input logic b, input int p, input bit glitch);
        for (int i = 0; i < p; i++) begin
            RX_IN = (glitch && i == p / 2) ? ~b : b;
            tick(1);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic [PW-1:0] presc,
                              input logic pen, input logic ptyp, input bit par_bad,
                              input logic stop_bit, input int glitch_bit,
                              input logic [PW-1:0] mid_presc);
        int   p;
        logic pbit;
        bit   pf;
        bit   sf;
        p        = eff_presc(presc);
        PRESCALE = presc;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        // Correct parity bit makes the total count of ones even (or odd).
        pbit = logic'(($countones(data) % 2) != 0) ^ ptyp;
        if (par_bad) pbit = ~pbit;
        pf = pen && par_bad;
        sf = (stop_bit == 1'b0);
        if (!pf && !sf) begin
            exp_q.push_back(data);
            exp_pulses++;
        end
        send_bit(1'b0, p, 1'b0);
        if (mid_presc != presc) begin
            PRESCALE = mid_presc;
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
        end
        for (int i = 0; i < DW; i++) send_bit(data[i], p, glitch_bit == i);
        if (pen) send_bit(pbit, p, 1'b0);
        send_bit(stop_bit, p, 1'b0);
        RX_IN = 1'b1;
        m_par = pf;
        m_stp = sf;
        if (!pf && !sf) m_data = data;
    endtask

    task automatic idle_check(input string tag, input int n);
        RX_IN = 1'b1;
        tick(n);
        check({tag, "_p_data"}, 32'(P_DATA), 32'(m_data));
        check({tag, "_par_err"}, 32'(PAR_ERR), 32'(m_par));
        check({tag, "_stp_err"}, 32'(STP_ERR), 32'(m_stp));
    endtask

    logic [PW-1:0] presc_tab[6] = '{6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd24};

    initial begin
        RST      = 1'b1;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        tick(3);
        check("rst_p_data", 32'(P_DATA), 32'd0);
        check("rst_valid", 32'(DATA_VALID), 32'd0);
        check("rst_par_err", 32'(PAR_ERR), 32'd0);
        check("rst_stp_err", 32'(STP_ERR), 32'd0);
        RST = 1'b0;
        tick(4);

        send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 6'd8);
        idle_check("basic", 12);

        send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 6'd16);
        idle_check("par_ok", 20);
        send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 6'd16);
        idle_check("par_bad", 20);

        send_frame(8'h01, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, -1, 6'd32);
        idle_check("stop_bad", 36);

        // Three-cycle low pulse must not disturb the held flags.
        PRESCALE = 6'd8;
        RX_IN    = 1'b0;
        tick(3);
        idle_check("start_glitch", 20);

        send_frame(8'h96, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 6'd8);
        idle_check("vote", 12);

        send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 6'd8);
        send_frame(8'hAA, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 6'd8);
        idle_check("b2b", 12);

        // Abort a frame partway through a data bit.
        PRESCALE = 6'd8;
        send_bit(1'b0, 8, 1'b0);
        send_bit(1'b1, 8, 1'b0);
        send_bit(1'b0, 8, 1'b0);
        RX_IN = 1'b1;
        tick(3);
        #2 RST = 1'b1;
        #1;
        check("midrst_p_data", 32'(P_DATA), 32'd0);
        check("midrst_valid", 32'(DATA_VALID), 32'd0);
        m_data = '0;
        m_par  = 1'b0;
        m_stp  = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        tick(4);
        send_frame(8'h7E, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 6'd8);
        idle_check("after_rst", 12);

        send_frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 6'd16);
        idle_check("presc_mid", 12);
        send_frame(8'h5A, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 6'd16);
        idle_check("presc_next", 20);

        for (int n = 0; n < 30; n++) begin
            logic [PW-1:0] pr;
            logic [PW-1:0] mid;
            pr  = presc_tab[$urandom_range(0, 5)];
            mid = ($urandom_range(0, 2) == 0) ? presc_tab[$urandom_range(0, 5)] : pr;
            send_frame(8'($urandom), pr, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : -1, mid);
            idle_check("rand", eff_presc(pr) + 4);
        end

        tick(10);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
